gyro_packet_rx: RTL

//  UART receiver and frame parser for the gyro telemetry stream (8N1, LSB first).
//  It recovers bytes from the serial line and reassembles axis data from 8-byte frames:
//  {x[7:0], x[15:8], y[7:0], y[15:8], z[7:0], z[15:8], 8'h55, 8'h55}.
//  It is the host/board-side counterpart of the gyro UART transmit path.
//  It is used for loopback checks and for board-to-board relaying of axis data.

---
 rtl/gyro_rx_pkg.sv | 17 +
 rtl/uart_rx_core.sv | 109 ++++++++++
 rtl/gyro_packet_rx.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/gyro_rx_pkg.sv
// gyro_rx_pkg
// Shared constants and state encodings for the gyro telemetry receiver.
//   SYNC_BYTE    frame trailer / hunt pattern (8'h55)
//   PAYLOAD_LEN  axis bytes per frame (x lo/hi, y lo/hi, z lo/hi)
//   TRAILER_LEN  trailer bytes per frame
//   byte_state_t   UART byte FSM states
//   parser_state_t frame parser states
package gyro_rx_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'h55;
  localparam int         PAYLOAD_LEN = 6;
  localparam int         TRAILER_LEN = 2;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} byte_state_t;
  typedef enum logic [1:0] {HUNT, PAYLOAD, TRAILER}         parser_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core
// 8N1 UART byte receiver (LSB first): 2-flop synchronizer, bit timer, byte FSM.
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   rx         in   serial line, idles high, asynchronous to clk
//   byte_data  out  last good byte
//   byte_valid out  1-cycle pulse when byte_data is updated
//   frame_err  out  1-cycle pulse when a stop bit is sampled low
// Parameter CLKS_PER_BIT: clk cycles per UART bit (>= 4).
import gyro_rx_pkg::*;

module uart_rx_core #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  // The timer counts down and expires at zero, so loads are one less than
  // the wanted interval.
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);

  logic          rx_meta, rx_sync, rx_d;
  byte_state_t   state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tick;

  assign tick = (timer == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_d       <= 1'b1;
      state      <= IDLE;
      timer      <= '0;
      bit_idx    <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_d       <= rx_sync;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (!tick) timer <= timer - 1'b1;
      case (state)
        IDLE: begin
          if (rx_d && !rx_sync) begin
            state <= START;
            timer <= HALF_LOAD;
          end
        end
        START: begin
          if (tick) begin
            // A line that is high again at mid start bit was only a glitch.
            if (!rx_sync) begin
              state   <= DATA;
              timer   <= FULL_LOAD;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (tick) begin
            timer   <= FULL_LOAD;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            if (rx_sync) begin
              byte_data  <= shreg;
              byte_valid <= 1'b1;
              state      <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end
        end
        BREAK: begin
          // Held-low line: stay here so only one frame_err is reported.
          if (rx_sync) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data shift register carries no reset; it is only read after 8 shifts.
  always_ff @(posedge clk) begin
    if (state == DATA && tick) shreg <= {rx_sync, shreg[7:1]};
  end

endmodule

// File: rtl/gyro_packet_rx.sv
// gyro_packet_rx
// UART receiver and frame parser for the gyro telemetry stream. Frames are
// {x lo, x hi, y lo, y hi, z lo, z hi, 55, 55}; axis outputs update only on
// a complete, correctly trailed frame.
// Ports:
//   clk, reset (async active-low), rx (serial in)
//   byte_data/byte_valid   received byte and its pulse
//   x/y/z_axis_data        last committed axis values
//   frame_valid            pulse when the axis outputs update
//   synced                 high while locked to frame boundaries
//   frame_err              pulse on a low stop bit
//   sync_lost              pulse on a bad trailer byte
//   frame_err_cnt/sync_loss_cnt  saturating counters (GYRO_RX_STATS_EN only)
// Optional feature macro: GYRO_RX_STATS_EN.
import gyro_rx_pkg::*;

module gyro_packet_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic [15:0] x_axis_data,
  output logic [15:0] y_axis_data,
  output logic [15:0] z_axis_data,
  output logic        frame_valid,
  output logic        synced,
  output logic        frame_err,
  output logic        sync_lost
`ifdef GYRO_RX_STATS_EN
  ,
  output logic [7:0]  frame_err_cnt,
  output logic [7:0]  sync_loss_cnt
`endif
);

  localparam logic [2:0] LAST_PAYLOAD = 3'(PAYLOAD_LEN - 1);
  localparam logic [2:0] LAST_TRAILER = 3'(TRAILER_LEN - 1);

  parser_state_t state;
  logic [2:0]    idx;
  logic [7:0]    shadow [0:PAYLOAD_LEN-1];

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  // idx is the consecutive-55 count in HUNT and the byte position in
  // PAYLOAD/TRAILER.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= HUNT;
      idx         <= '0;
      synced      <= 1'b0;
      frame_valid <= 1'b0;
      sync_lost   <= 1'b0;
      x_axis_data <= '0;
      y_axis_data <= '0;
      z_axis_data <= '0;
    end else begin
      frame_valid <= 1'b0;
      sync_lost   <= 1'b0;
      if (frame_err) begin
        // Shadow contents are abandoned; they are overwritten before any commit.
        state  <= HUNT;
        idx    <= '0;
        synced <= 1'b0;
      end else if (byte_valid) begin
        case (state)
          HUNT: begin
            if (byte_data == SYNC_BYTE) begin
              if (idx == LAST_TRAILER) begin
                state  <= PAYLOAD;
                idx    <= '0;
                synced <= 1'b1;
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              idx <= '0;
            end
          end
          PAYLOAD: begin
            if (idx == LAST_PAYLOAD) begin
              state <= TRAILER;
              idx   <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
          TRAILER: begin
            if (byte_data != SYNC_BYTE) begin
              sync_lost <= 1'b1;
              synced    <= 1'b0;
              state     <= HUNT;
              idx       <= '0;
            end else if (idx == LAST_TRAILER) begin
              x_axis_data <= {shadow[1], shadow[0]};
              y_axis_data <= {shadow[3], shadow[2]};
              z_axis_data <= {shadow[5], shadow[4]};
              frame_valid <= 1'b1;
              state       <= PAYLOAD;
              idx         <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
          default: begin
            state <= HUNT;
            idx   <= '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (byte_valid && state == PAYLOAD) shadow[idx] <= byte_data;
  end

`ifdef GYRO_RX_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_err_cnt <= '0;
      sync_loss_cnt <= '0;
    end else begin
      if (frame_err && frame_err_cnt != 8'hFF) frame_err_cnt <= frame_err_cnt + 8'd1;
      if (sync_lost && sync_loss_cnt != 8'hFF) sync_loss_cnt <= sync_loss_cnt + 8'd1;
    end
  end
`endif

endmodule
